// File: rtl/sha256_digest_emitter.sv
// ---------------------------------------------------------------------------
// sha256_digest_emitter
// Captures a SHA-256 digest on the rising edge of the processor's done level
// and streams it out one byte per handshake. The bytes are either lowercase
// ASCII hex (64 beats) or raw (32 beats), optionally followed by a newline
// beat. At capture it also compares the digest against an expected value.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   done_in      processor done level; a 0->1 transition is a capture event
//   hash_in      digest, word a in [255:224]
//   expect_in    expected digest, sampled at capture
//   expect_en    compare enable, sampled at capture
//   out_data     stream byte
//   out_valid    stream valid
//   out_ready    sink ready
//   out_last     marks the final beat of a digest
//   busy         high from capture until the final handshake
//   match        digest equalled expect_in (valid when match_valid)
//   match_valid  a compare result is present
//   overrun      sticky: a capture event arrived while streaming
// ---------------------------------------------------------------------------
module sha256_digest_emitter #(
    parameter bit HEX_MODE  = 1'b1,
    parameter bit APPEND_NL = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         done_in,
    input  logic [255:0] hash_in,
    input  logic [255:0] expect_in,
    input  logic         expect_en,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         match,
    output logic         match_valid,
    output logic         overrun
);

    localparam int unsigned HASH_W      = 256;
    localparam int unsigned CNT_W       = 7;
    localparam int unsigned UNIT_W      = HEX_MODE ? 4 : 8;
    localparam int unsigned TOTAL_BEATS = (HEX_MODE ? 64 : 32) + (APPEND_NL ? 1 : 0);
    localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       NL_CHAR   = 8'h0A;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Registers
    state_t             r_state;
    logic               r_done_q;
    logic [HASH_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_busy;
    logic               r_match;
    logic               r_match_valid;
    logic               r_overrun;

    // Next-state / next-value wires
    state_t             w_state_nxt;
    logic [HASH_W-1:0]  w_shift_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_dec;
    logic [7:0]         w_out_data_nxt;
    logic               w_out_valid_nxt;
    logic               w_out_last_nxt;
    logic               w_busy_nxt;
    logic               w_match_nxt;
    logic               w_match_valid_nxt;
    logic               w_overrun_nxt;
    logic               w_capture;
    logic               w_xfer;
    logic               w_final_xfer;

    // Nibble to lowercase ASCII hex character.
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            nib2ascii = 8'h30 + {4'h0, n};
        end else begin
            nib2ascii = 8'h57 + {4'h0, n};
        end
    endfunction

    // Beat presented for the most significant unit of a digest vector.
    function automatic logic [7:0] beat_of(input logic [HASH_W-1:0] v);
        if (HEX_MODE) begin
            beat_of = nib2ascii(v[HASH_W-1 -: 4]);
        end else begin
            beat_of = v[HASH_W-1 -: 8];
        end
    endfunction

    assign w_capture    = done_in & ~r_done_q;
    assign w_xfer       = r_out_valid & out_ready;
    assign w_final_xfer = w_xfer & (r_cnt == CNT_ONE);
    assign w_cnt_dec    = r_cnt - CNT_ONE;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_final_xfer) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values; all of these are registered below.
    always_comb begin
        w_shift_nxt       = r_shift;
        w_cnt_nxt         = r_cnt;
        w_out_data_nxt    = r_out_data;
        w_out_valid_nxt   = r_out_valid;
        w_out_last_nxt    = r_out_last;
        w_busy_nxt        = r_busy;
        w_match_nxt       = r_match;
        w_match_valid_nxt = r_match_valid;
        w_overrun_nxt     = r_overrun;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    // First beat goes out the cycle after capture; the shift
                    // register already holds the remainder.
                    w_shift_nxt       = hash_in << UNIT_W;
                    w_cnt_nxt         = TOTAL_CNT;
                    w_out_data_nxt    = beat_of(hash_in);
                    w_out_valid_nxt   = 1'b1;
                    w_out_last_nxt    = 1'b0;  // a stream always has 32+ beats
                    w_busy_nxt        = 1'b1;
                    w_match_valid_nxt = expect_en;
                    w_match_nxt       = expect_en && (hash_in == expect_in);
                end
            end
            ST_EMIT: begin
                // Capture events while streaming are dropped but remembered.
                if (w_capture) begin
                    w_overrun_nxt = 1'b1;
                end
                if (w_final_xfer) begin
                    w_cnt_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_busy_nxt      = 1'b0;
                end else if (w_xfer) begin
                    // r_cnt counts beats left including the one on the bus.
                    w_cnt_nxt      = w_cnt_dec;
                    w_out_last_nxt = (w_cnt_dec == CNT_ONE);
                    if (APPEND_NL && (w_cnt_dec == CNT_ONE)) begin
                        w_out_data_nxt = NL_CHAR;
                    end else begin
                        w_out_data_nxt = beat_of(r_shift);
                        w_shift_nxt    = r_shift << UNIT_W;
                    end
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_out_last_nxt  = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done_q      <= 1'b0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_match       <= 1'b0;
            r_match_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_done_q      <= done_in;
            r_shift       <= w_shift_nxt;
            r_cnt         <= w_cnt_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_last    <= w_out_last_nxt;
            r_busy        <= w_busy_nxt;
            r_match       <= w_match_nxt;
            r_match_valid <= w_match_valid_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign busy        = r_busy;
    assign match       = r_match;
    assign match_valid = r_match_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_sha256_digest_emitter.sv
// ---------------------------------------------------------------------------
// tb_sha256_digest_emitter
// Drives a hex+newline instance (index 0) and a raw/no-terminator instance
// (index 1) from shared stimulus and checks every output of both, every
// cycle, against a beat-list model of the expected stream.
// ---------------------------------------------------------------------------
module tb_sha256_digest_emitter;

    localparam logic [255:0] ABC_HASH =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         done_in;
    logic [255:0] hash_in;
    logic [255:0] expect_in;
    logic         expect_en;
    logic [1:0]   rdy;

    logic [7:0]   o_data  [2];
    logic         o_valid [2];
    logic         o_last  [2];
    logic         o_busy  [2];
    logic         o_match [2];
    logic         o_mv    [2];
    logic         o_ovr   [2];

    always #5 clk = ~clk;

    sha256_digest_emitter #(.HEX_MODE(1'b1), .APPEND_NL(1'b1)) u_hex (
        .clk(clk), .rst_n(rst_n), .done_in(done_in), .hash_in(hash_in),
        .expect_in(expect_in), .expect_en(expect_en),
        .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(rdy[0]),
        .out_last(o_last[0]), .busy(o_busy[0]), .match(o_match[0]),
        .match_valid(o_mv[0]), .overrun(o_ovr[0])
    );

    sha256_digest_emitter #(.HEX_MODE(1'b0), .APPEND_NL(1'b0)) u_raw (
        .clk(clk), .rst_n(rst_n), .done_in(done_in), .hash_in(hash_in),
        .expect_in(expect_in), .expect_en(expect_en),
        .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(rdy[1]),
        .out_last(o_last[1]), .busy(o_busy[1]), .match(o_match[1]),
        .match_valid(o_mv[1]), .overrun(o_ovr[1])
    );

    // Model state: the full list of beats for the current digest and a
    // read position into it.
    logic [7:0] m_beats [2][0:64];
    int         m_len   [2];
    int         m_pos   [2];
    logic [7:0] m_last  [2];
    logic       m_match [2];
    logic       m_mv    [2];
    logic       m_ovr   [2];
    logic       m_done_q;

    int n_cmp  = 0;
    int n_fail = 0;
    int xfer   [2];
    int rmode  = 0;
    int ph     = 0;
    logic [5:0] pat = 6'b101001;  // ready per cycle: 1,0,0,1,0,1

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
        return v;
    endfunction

    function automatic bit m_busy(input int i);
        return m_pos[i] < m_len[i];
    endfunction

    task automatic chk(input string nm, input int inst, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %h want %h", nm, inst, $time, act, exp);
        end
    endtask

    // Build the expected beat list for instance i from a digest.
    task automatic load(input int i, input logic [255:0] h);
        string hx;
        int n;
        logic [7:0] b;
        hx = "0123456789abcdef";
        n = 0;
        for (int k = 0; k < 32; k++) begin
            b = h[255-8*k -: 8];
            if (i == 0) begin
                m_beats[i][n] = hx[b[7:4]]; n++;
                m_beats[i][n] = hx[b[3:0]]; n++;
            end else begin
                m_beats[i][n] = b; n++;
            end
        end
        if (i == 0) begin
            m_beats[i][n] = 8'h0A; n++;
        end
        m_len[i] = n;
        m_pos[i] = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_update();
        bit cap;
        cap = done_in && !m_done_q;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_len[i] = 0; m_pos[i] = 0; m_last[i] = 8'h00;
                m_match[i] = 1'b0; m_mv[i] = 1'b0; m_ovr[i] = 1'b0;
            end else if (m_busy(i)) begin
                if (rdy[i]) begin
                    m_last[i] = m_beats[i][m_pos[i]];
                    m_pos[i]++;
                end
                if (cap) m_ovr[i] = 1'b1;
            end else if (cap) begin
                load(i, hash_in);
                m_mv[i]    = expect_en;
                m_match[i] = expect_en && (hash_in == expect_in);
            end
        end
        m_done_q = rst_n ? done_in : 1'b0;
    endtask

    task automatic compare_all();
        bit b;
        for (int i = 0; i < 2; i++) begin
            b = m_busy(i);
            chk("out_valid", i, {7'd0, o_valid[i]}, {7'd0, b});
            chk("busy", i, {7'd0, o_busy[i]}, {7'd0, b});
            chk("out_data", i, o_data[i], b ? m_beats[i][m_pos[i]] : m_last[i]);
            chk("out_last", i, {7'd0, o_last[i]}, {7'd0, b && (m_pos[i] == m_len[i] - 1)});
            chk("match", i, {7'd0, o_match[i]}, {7'd0, m_match[i]});
            chk("match_valid", i, {7'd0, o_mv[i]}, {7'd0, m_mv[i]});
            chk("overrun", i, {7'd0, o_ovr[i]}, {7'd0, m_ovr[i]});
        end
    endtask

    // One clock: pick ready, count DUT handshakes, step model, then compare.
    task automatic cycle();
        case (rmode)
            0: rdy = 2'b11;
            1: rdy = {2{pat[ph % 6]}};
            default: rdy = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        endcase
        ph++;
        for (int i = 0; i < 2; i++) if (o_valid[i] === 1'b1 && rdy[i]) xfer[i]++;
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while ((m_busy(0) || m_busy(1)) && n < maxc) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (m_busy(0) || m_busy(1)) begin
            n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles, want idle", n);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_len[i] = 0; m_pos[i] = 0; m_last[i] = 8'h00;
            m_match[i] = 1'b0; m_mv[i] = 1'b0; m_ovr[i] = 1'b0;
            xfer[i] = 0;
        end
        m_done_q = 1'b0;
        rst_n = 1'b0; done_in = 1'b0; hash_in = '0; expect_in = '0; expect_en = 1'b0; rdy = 2'b11;
        @(negedge clk);

        // Reset
        repeat (3) cycle();
        chk("reset_busy", 0, {7'd0, o_busy[0]}, 8'd0);
        chk("reset_data", 1, o_data[1], 8'h00);
        rst_n = 1'b1;
        cycle();

        // Hex+NL and raw streams of SHA-256("abc") at full throughput
        hash_in = ABC_HASH; expect_in = ABC_HASH; expect_en = 1'b1; done_in = 1'b1;
        xfer[0] = 0; xfer[1] = 0;
        cycle();
        chk("pin_hex_len", 0, 8'(m_len[0]), 8'd65);
        chk("pin_raw_len", 1, 8'(m_len[1]), 8'd32);
        chk("pin_hex_b0", 0, m_beats[0][0], 8'h62);
        chk("pin_hex_b1", 0, m_beats[0][1], 8'h61);
        chk("pin_hex_b2", 0, m_beats[0][2], 8'h37);
        chk("pin_hex_b3", 0, m_beats[0][3], 8'h38);
        chk("pin_hex_b63", 0, m_beats[0][63], 8'h64);
        chk("pin_hex_b64", 0, m_beats[0][64], 8'h0A);
        chk("pin_raw_b0", 1, m_beats[1][0], 8'hba);
        chk("pin_raw_b31", 1, m_beats[1][31], 8'had);
        chk("first_beat", 0, o_data[0], 8'h62);
        chk("first_beat", 1, o_data[1], 8'hba);
        chk("first_match", 0, {7'd0, o_match[0]}, 8'd1);
        run_until_idle(200);
        chk("beats_full", 0, 8'(xfer[0]), 8'd65);
        chk("beats_full", 1, 8'(xfer[1]), 8'd32);

        // Backpressure pattern, expected value off by bit 0
        done_in = 1'b0; cycle();
        rmode = 1; ph = 0;
        expect_in = ABC_HASH ^ 256'd1; done_in = 1'b1;
        xfer[0] = 0; xfer[1] = 0;
        cycle();
        chk("mismatch_match", 0, {7'd0, o_match[0]}, 8'd0);
        chk("mismatch_mv", 0, {7'd0, o_mv[0]}, 8'd1);
        run_until_idle(500);
        chk("beats_bp", 0, 8'(xfer[0]), 8'd65);
        chk("beats_bp", 1, 8'(xfer[1]), 8'd32);

        // Compare disabled, then overrun around beat 10
        rmode = 0;
        done_in = 1'b0; cycle();
        hash_in = rand256(); expect_in = hash_in; expect_en = 1'b0; done_in = 1'b1;
        cycle();
        chk("noen_mv", 0, {7'd0, o_mv[0]}, 8'd0);
        done_in = 1'b0;
        repeat (9) cycle();
        done_in = 1'b1; hash_in = rand256();
        cycle();
        chk("overrun_set", 0, {7'd0, o_ovr[0]}, 8'd1);
        chk("overrun_set", 1, {7'd0, o_ovr[1]}, 8'd1);
        run_until_idle(200);
        done_in = 1'b0; cycle();
        hash_in = rand256(); expect_in = hash_in; expect_en = 1'b1; done_in = 1'b1;
        cycle();
        chk("recapture_match", 0, {7'd0, o_match[0]}, 8'd1);
        chk("overrun_sticky", 0, {7'd0, o_ovr[0]}, 8'd1);
        run_until_idle(200);

        // Randomized done toggling, digests and backpressure
        rmode = 2;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                done_in = ~done_in;
                hash_in = rand256();
                expect_in = ($urandom_range(0, 1) == 1) ? hash_in : (hash_in ^ (256'd1 << $urandom_range(0, 255)));
                expect_en = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        run_until_idle(1000);

        // Reset mid-stream with done_in held high through reset
        rmode = 0;
        done_in = 1'b0; cycle();
        hash_in = rand256(); expect_in = hash_in; expect_en = 1'b1; done_in = 1'b1;
        repeat (21) cycle();
        rst_n = 1'b0;
        cycle();
        chk("rst_valid", 0, {7'd0, o_valid[0]}, 8'd0);
        chk("rst_busy", 1, {7'd0, o_busy[1]}, 8'd0);
        chk("rst_ovr", 0, {7'd0, o_ovr[0]}, 8'd0);
        chk("rst_mv", 0, {7'd0, o_mv[0]}, 8'd0);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_capture", 0, {7'd0, o_busy[0]}, 8'd1);
        chk("post_rst_capture", 1, {7'd0, o_valid[1]}, 8'd1);
        run_until_idle(200);
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
